// File: rtl/vblank_access_arbiter.sv
// Round-robin arbiter that grants one requester at a time, only inside the
// vertical blanking window. Grants end on done, on a dropped request, on a
// hold-time timeout, or when blanking ends. All logic is in the pclk domain.
//
// Ports:
//   pclk, rst_n   pixel clock, asynchronous active-low reset
//   vblnk_in      vertical blanking level from the timing generator
//   req, done     request levels and one-cycle completion strobes
//   gnt, gnt_id   registered one-hot grant and index of current/last grant
//   window_open   high while inside a blanking window
//   frame_tick    one-cycle pulse when the window opens
//   timeout_err   one-cycle pulse on a forced release after MAX_HOLD cycles
//   grant_count   saturating count of done-completed grants this window
module vblank_access_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 255,
    parameter int CNT_W    = 8
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic             vblnk_in,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] gnt,
    output logic [2:0]       gnt_id,
    output logic             window_open,
    output logic             frame_tick,
    output logic             timeout_err,
    output logic [CNT_W-1:0] grant_count
);

    localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        GRANT = 2'd2
    } state_t;

    state_t           state, state_d;
    logic             vblnk_q;
    logic [2:0]       rr_ptr, rr_d;
    logic [HW-1:0]    hold_cnt, hold_d;
    logic [N_REQ-1:0] gnt_d;
    logic [2:0]       gnt_id_d;
    logic             window_d, tick_d, terr_d;
    logic [CNT_W-1:0] cnt_d;

    logic             rise, fall;
    logic             g_done, g_req;
    logic [2:0]       rr_nxt;

    logic [2*N_REQ-1:0] rot;
    logic               pick_ok;
    int                 pick_i;
    logic [N_REQ-1:0]   pick_oh;

    assign rise = vblnk_in & ~vblnk_q;
    assign fall = ~vblnk_in & vblnk_q;

    // gnt is one-hot for gnt_id while granting, so masking avoids
    // a variable bit-select on done/req.
    assign g_done = |(done & gnt);
    assign g_req  = |(req & gnt);

    assign rr_nxt = (gnt_id == 3'(N_REQ - 1)) ? 3'd0 : gnt_id + 3'd1;

    // Rotate so bit 0 is the rr_ptr requester; first set bit wins.
    always_comb begin
        rot     = {req, req} >> rr_ptr;
        pick_ok = 1'b0;
        pick_i  = 0;
        pick_oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!pick_ok && rot[i]) begin
                pick_ok = 1'b1;
                pick_i  = int'(rr_ptr) + i;
                if (pick_i >= N_REQ) pick_i = pick_i - N_REQ;
            end
        end
        for (int k = 0; k < N_REQ; k++) begin
            pick_oh[k] = pick_ok && (k == pick_i);
        end
    end

    always_comb begin
        state_d  = state;
        gnt_d    = gnt;
        gnt_id_d = gnt_id;
        window_d = window_open;
        tick_d   = 1'b0;
        terr_d   = 1'b0;
        cnt_d    = grant_count;
        rr_d     = rr_ptr;
        hold_d   = hold_cnt;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    state_d  = ARB;
                    window_d = 1'b1;
                    tick_d   = 1'b1;
                    cnt_d    = '0;
                end
            end
            ARB: begin
                if (fall) begin
                    state_d  = IDLE;
                    window_d = 1'b0;
                end else if (pick_ok) begin
                    gnt_d    = pick_oh;
                    gnt_id_d = 3'(pick_i);
                    hold_d   = '0;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                if (g_done || !g_req) begin
                    gnt_d = '0;
                    rr_d  = rr_nxt;
                    if (g_done && grant_count != '1)
                        cnt_d = grant_count + 1'b1;
                    state_d = fall ? IDLE : ARB;
                    if (fall) window_d = 1'b0;
                end else if (hold_cnt == HW'(MAX_HOLD - 1)) begin
                    gnt_d   = '0;
                    terr_d  = 1'b1;
                    rr_d    = rr_nxt;
                    state_d = fall ? IDLE : ARB;
                    if (fall) window_d = 1'b0;
                end else if (fall) begin
                    // Preempted requester keeps priority next frame.
                    gnt_d    = '0;
                    rr_d     = gnt_id;
                    state_d  = IDLE;
                    window_d = 1'b0;
                end else begin
                    hold_d = hold_cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // vblnk_q resets high so leaving reset inside blanking opens no window.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            vblnk_q     <= 1'b1;
            rr_ptr      <= '0;
            hold_cnt    <= '0;
            gnt         <= '0;
            gnt_id      <= '0;
            window_open <= 1'b0;
            frame_tick  <= 1'b0;
            timeout_err <= 1'b0;
            grant_count <= '0;
        end else begin
            state       <= state_d;
            vblnk_q     <= vblnk_in;
            rr_ptr      <= rr_d;
            hold_cnt    <= hold_d;
            gnt         <= gnt_d;
            gnt_id      <= gnt_id_d;
            window_open <= window_d;
            frame_tick  <= tick_d;
            timeout_err <= terr_d;
            grant_count <= cnt_d;
        end
    end

endmodule

// File: tb/tb_vblank_access_arbiter.sv
// Directed testbench for vblank_access_arbiter (N_REQ=4, MAX_HOLD=16).
// Expected values are hand-computed per step; outputs sampled 1 ns after pclk rise.
module tb_vblank_access_arbiter;

    logic       pclk = 1'b0;
    logic       rst_n;
    logic       vblnk_in;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic [2:0] gnt_id;
    logic       window_open;
    logic       frame_tick;
    logic       timeout_err;
    logic [7:0] grant_count;

    int n_cmp = 0;
    int n_bad = 0;

    vblank_access_arbiter #(
        .N_REQ(4),
        .MAX_HOLD(16),
        .CNT_W(8)
    ) dut (
        .pclk(pclk),
        .rst_n(rst_n),
        .vblnk_in(vblnk_in),
        .req(req),
        .done(done),
        .gnt(gnt),
        .gnt_id(gnt_id),
        .window_open(window_open),
        .frame_tick(frame_tick),
        .timeout_err(timeout_err),
        .grant_count(grant_count)
    );

    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        vblnk_in = 1'b0;
        req      = 4'b0000;
        done     = 4'b0000;
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_gnt_id", 32'(gnt_id), 32'h0);
        chk("rst_window", 32'(window_open), 32'h0);
        chk("rst_tick", 32'(frame_tick), 32'h0);
        chk("rst_terr", 32'(timeout_err), 32'h0);
        chk("rst_count", 32'(grant_count), 32'h0);
        rst_n = 1'b1;
        tick();

        // Test 1: single requester, done 8 cycles after grant
        req      = 4'b0001;
        vblnk_in = 1'b1;
        tick();
        chk("t1_tick", 32'(frame_tick), 32'h1);
        chk("t1_window", 32'(window_open), 32'h1);
        chk("t1_gnt_k", 32'(gnt), 32'h0);
        tick();
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_gnt_id", 32'(gnt_id), 32'h0);
        chk("t1_tick_off", 32'(frame_tick), 32'h0);
        for (int i = 0; i < 7; i++) tick();
        chk("t1_gnt_hold", 32'(gnt), 32'h1);
        done = 4'b0001;
        tick();
        chk("t1_gnt_rel", 32'(gnt), 32'h0);
        chk("t1_count", 32'(grant_count), 32'h1);
        done = 4'b0000;
        req  = 4'b0000;
        tick();
        chk("t1_idle", 32'(gnt), 32'h0);

        // Re-initialise so round-robin starts at 0
        rst_n    = 1'b0;
        vblnk_in = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Test 2: all request, done 3 cycles after each grant
        req      = 4'b1111;
        vblnk_in = 1'b1;
        tick();
        chk("t2_tick", 32'(frame_tick), 32'h1);
        for (int g = 0; g < 6; g++) begin
            tick();
            chk("t2_gnt", 32'(gnt), 32'(4'b0001 << (g % 4)));
            chk("t2_gnt_id", 32'(gnt_id), 32'(g % 4));
            tick();
            tick();
            done = 4'(4'b0001 << (g % 4));
            tick();
            chk("t2_gap", 32'(gnt), 32'h0);
            done = 4'b0000;
        end
        chk("t2_count", 32'(grant_count), 32'h6);

        // Test 4: grant to 2 preempted by end of blanking
        tick();
        chk("t4_gnt", 32'(gnt), 32'h4);
        vblnk_in = 1'b0;
        tick();
        chk("t4_gnt_off", 32'(gnt), 32'h0);
        chk("t4_window", 32'(window_open), 32'h0);
        chk("t4_terr", 32'(timeout_err), 32'h0);
        vblnk_in = 1'b1;
        tick();
        chk("t4_tick", 32'(frame_tick), 32'h1);
        chk("t4_count0", 32'(grant_count), 32'h0);
        tick();
        chk("t4_first", 32'(gnt), 32'h4);

        // Test 5: done[1] together with blanking end
        done = 4'b0100;
        tick();
        chk("t5_rel2", 32'(gnt), 32'h0);
        done = 4'b0000;
        tick();
        chk("t5_g3", 32'(gnt), 32'h8);
        done = 4'b1000;
        tick();
        done = 4'b0000;
        tick();
        chk("t5_g0", 32'(gnt), 32'h1);
        done = 4'b0001;
        tick();
        done = 4'b0000;
        tick();
        chk("t5_g1", 32'(gnt), 32'h2);
        chk("t5_cnt3", 32'(grant_count), 32'h3);
        done     = 4'b0010;
        vblnk_in = 1'b0;
        tick();
        done = 4'b0000;
        chk("t5_gnt_off", 32'(gnt), 32'h0);
        chk("t5_window", 32'(window_open), 32'h0);
        chk("t5_count", 32'(grant_count), 32'h4);
        chk("t5_terr", 32'(timeout_err), 32'h0);
        vblnk_in = 1'b1;
        tick();
        chk("t5_tick", 32'(frame_tick), 32'h1);
        tick();
        chk("t5_first", 32'(gnt), 32'h4);

        // Test 3: only requester 2, no done -> timeout after 16 cycles
        req = 4'b0100;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("t3_hold", 32'(gnt), 32'h4);
            chk("t3_noterr", 32'(timeout_err), 32'h0);
        end
        tick();
        chk("t3_rel", 32'(gnt), 32'h0);
        chk("t3_terr", 32'(timeout_err), 32'h1);
        chk("t3_count", 32'(grant_count), 32'h0);
        req = 4'b1111;
        tick();
        chk("t3_terr_off", 32'(timeout_err), 32'h0);
        chk("t3_next", 32'(gnt), 32'h8);

        // Test 6: asynchronous reset mid-grant, released inside blanking
        rst_n = 1'b0;
        #1;
        chk("t6_async_gnt", 32'(gnt), 32'h0);
        chk("t6_async_win", 32'(window_open), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_no_tick", 32'(frame_tick), 32'h0);
        tick();
        chk("t6_no_tick2", 32'(frame_tick), 32'h0);
        chk("t6_no_gnt", 32'(gnt), 32'h0);
        vblnk_in = 1'b0;
        tick();
        vblnk_in = 1'b1;
        tick();
        chk("t6_tick", 32'(frame_tick), 32'h1);
        chk("t6_window", 32'(window_open), 32'h1);
        tick();
        chk("t6_gnt", 32'(gnt), 32'h1);
        chk("t6_tick_off", 32'(frame_tick), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
